// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/ack bus transaction per memory instruction, stalling the pipe until done.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault without a bus request.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  mem_load_op,
  input  logic [1:0]  mem_store_op,
  input  logic        mem_bus_we,
  input  logic [31:0] mem_alu_cal,
  input  logic [31:0] mem_rf_rd2,
  output logic        lsu_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_is_load;
  logic            w_access;
  logic            w_trap;
  logic            w_launch;
  logic            w_finish;
  logic            w_fault_nxt;
  logic            w_stall;
  logic [1:0]      w_off;
  logic [BW-1:0]   w_be;
  logic [DW-1:0]   w_wdata;
  logic [DW-1:0]   w_load_ext;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  logic            r_bus_req;
  logic            r_bus_we;
  logic            r_done;
  logic            r_fault;
  logic [DW-1:0]   r_addr;
  logic [BW-1:0]   r_be;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic [TO_W-1:0] r_to_cnt;
  logic [2:0]      r_ld_op;
  logic [1:0]      r_off;

  assign w_is_load = (mem_load_op >= 3'd1) && (mem_load_op <= 3'd5);
  assign w_access  = mem_bus_we | w_is_load;
  assign w_off     = mem_alu_cal[1:0];

  // Lane decode: byte enables, replicated store data, misalignment trap
  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    w_trap  = 1'b0;
    if (mem_bus_we) begin
      case (mem_store_op)
        2'd0: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{mem_rf_rd2[7:0]}};
        end
        2'd1: begin
          w_be    = w_off[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{mem_rf_rd2[15:0]}};
`ifdef LSU_MISALIGN_TRAP_EN
          w_trap  = w_off[0];
`endif
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = mem_rf_rd2;
`ifdef LSU_MISALIGN_TRAP_EN
          w_trap  = |w_off;
`endif
        end
      endcase
    end else begin
      case (mem_load_op)
        3'd1, 3'd2: w_be = 4'b0001 << w_off;
        3'd3, 3'd4: begin
          w_be = w_off[1] ? 4'b1100 : 4'b0011;
`ifdef LSU_MISALIGN_TRAP_EN
          w_trap = w_off[0];
`endif
        end
        3'd5: begin
          w_be = 4'b1111;
`ifdef LSU_MISALIGN_TRAP_EN
          w_trap = |w_off;
`endif
        end
        default: w_be = '0;
      endcase
    end
  end

  // Load lane select and extension from the captured op/offset
  always_comb begin
    case (r_off)
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_ld_op)
      3'd1:    w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_load_ext = {24'd0, w_byte};
      3'd3:    w_load_ext = {{16{w_half[15]}}, w_half};
      3'd4:    w_load_ext = {16'd0, w_half};
      3'd5:    w_load_ext = bus_rdata;
      default: w_load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    w_fault_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_stall = 1'b1;
          if (w_trap) begin
            w_state_nxt = S_DONE;
            w_finish    = 1'b1;
            w_fault_nxt = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
            w_launch    = 1'b1;
          end
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (bus_ack) begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
        end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
          w_state_nxt = S_DONE;
          w_finish    = 1'b1;
          w_fault_nxt = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus request/payload registers and load result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_req <= 1'b0;
      r_bus_we  <= 1'b0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_to_cnt  <= '0;
      r_ld_op   <= '0;
      r_off     <= '0;
    end else begin
      r_done  <= w_finish;
      r_fault <= w_fault_nxt;
      if (w_launch || (r_state == S_IDLE && w_finish)) begin
        r_addr    <= {mem_alu_cal[31:2], 2'b00};
        r_be      <= w_trap ? '0 : w_be;
        r_wdata   <= w_wdata;
        r_bus_we  <= mem_bus_we & ~w_trap;
        r_bus_req <= ~w_trap;
        r_ld_op   <= mem_bus_we ? 3'd0 : mem_load_op;
        r_off     <= w_off;
        r_to_cnt  <= '0;
      end else if (r_state == S_REQ) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
        if (w_finish) begin
          r_bus_req <= 1'b0;
          r_bus_we  <= 1'b0;
        end
      end
      if (w_finish) r_rdata <= w_fault_nxt ? '0 : w_load_ext;
    end
  end

  // No stall is requested while reset holds the unit idle
  assign lsu_stall = w_stall & rst_n;
  assign lsu_rdata = r_rdata;
  assign lsu_done  = r_done;
  assign lsu_fault = r_fault;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;

endmodule
